// File: rtl/hrfp_add_sched_pkg.sv
// hrfp_add_sched_pkg: shared operand width, id-width helper and scheduler FSM encodings.
package hrfp_add_sched_pkg;
    localparam int MSBBIT = 31;
    localparam int DW = MSBBIT + 1;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, IDLE = 2'd2} sched_state_e;
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hrfp_add_sched_if.sv
// hrfp_add_sched_if: requester-side request/grant and broadcast response bus.
interface hrfp_add_sched_if #(parameter int NREQ = 4);
    import hrfp_add_sched_pkg::*;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_data);
    modport slave (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/hrfp_rr_arbiter.sv
// hrfp_rr_arbiter: round-robin one-hot pick starting after the last granted index.
module hrfp_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_elig,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);
    logic [IW-1:0] r_ptr;
    logic          w_any;

    always_comb begin
        w_any = 1'b0;
        o_idx = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_any && i_elig[(int'(r_ptr) + k) % N]) begin
                w_any = 1'b1;
                o_idx = IW'((int'(r_ptr) + k) % N);
            end
        end
        o_grant = w_any ? (N'(1) << o_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= IW'(N - 1);
        else if (w_any)
            r_ptr <= o_idx;
    end
endmodule

// File: rtl/hrfp_add_sched.sv
// hrfp_add_sched: shares one fixed-latency adder among requesters with credits and drain.
// Define HRFP_SCHED_PERF_EN to add saturating issue/stall cycle counters.
module hrfp_add_sched import hrfp_add_sched_pkg::*; #(
    parameter int NREQ = 4,
    parameter int PIPELINESTAGES = 5,
    parameter int MAXOUT = 3
) (
    input  logic            clk,
    input  logic            rst,
    hrfp_add_sched_if.slave s_req,
    output logic            o_add_valid,
    output logic [DW-1:0]   o_add_a,
    output logic [DW-1:0]   o_add_b,
    input  logic [DW-1:0]   i_add_result,
    input  logic            i_drain_req,
    output logic            o_drain_done,
    output logic            o_busy
`ifdef HRFP_SCHED_PERF_EN
    ,
    output logic [31:0]     o_perf_busy_cycles,
    output logic [31:0]     o_perf_stall_cycles
`endif
);
    localparam int IW = idw(NREQ);
    localparam int CW = $clog2(MAXOUT + 1);

    logic [NREQ-1:0]           w_elig;
    logic [NREQ-1:0]           w_grant;
    logic [NREQ-1:0]           w_rsp;
    logic [IW-1:0]             w_idx;
    logic                      w_xfer;
    logic [IW-1:0]             r_add_id;
    logic [PIPELINESTAGES-1:0] r_tv;
    logic [IW-1:0]             r_tid [PIPELINESTAGES];
    logic [CW-1:0]             r_cnt [NREQ];
    sched_state_e              r_state;
    sched_state_e              w_state_nx;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            w_elig[i] = s_req.req_valid[i] && (r_cnt[i] < CW'(MAXOUT)) && (r_state == RUN) && !i_drain_req;
    end

    hrfp_rr_arbiter #(.N(NREQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_elig (w_elig),
        .o_grant(w_grant),
        .o_idx  (w_idx)
    );

    assign w_xfer          = |w_grant;
    assign s_req.req_ready = w_grant;
    // The adder has no reset, so its output is only exposed alongside a live tag.
    assign w_rsp           = r_tv[PIPELINESTAGES-1] ? (NREQ'(1) << r_tid[PIPELINESTAGES-1]) : '0;
    assign s_req.rsp_valid = w_rsp;
    assign s_req.rsp_data  = r_tv[PIPELINESTAGES-1] ? i_add_result : '0;
    assign o_busy          = (|r_tv) | o_add_valid;
    assign o_drain_done    = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_add_valid <= 1'b0;
            o_add_a     <= '0;
            o_add_b     <= '0;
            r_add_id    <= '0;
            r_tv        <= '0;
        end else begin
            o_add_valid <= w_xfer;
            r_tv        <= (r_tv << 1) | PIPELINESTAGES'(o_add_valid);
            if (w_xfer) begin
                o_add_a  <= s_req.req_a[w_idx*DW +: DW];
                o_add_b  <= s_req.req_b[w_idx*DW +: DW];
                r_add_id <= w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tid[0] <= r_add_id;
        for (int k = 1; k < PIPELINESTAGES; k++)
            r_tid[k] <= r_tid[k-1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst)
                r_cnt[i] <= '0;
            else if (w_grant[i] && !w_rsp[i])
                r_cnt[i] <= r_cnt[i] + CW'(1);
            else if (!w_grant[i] && w_rsp[i])
                r_cnt[i] <= r_cnt[i] - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_state <= rst ? RUN : w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RUN:     w_state_nx = i_drain_req ? DRAIN : RUN;
            DRAIN:   w_state_nx = !i_drain_req ? RUN : (o_busy ? DRAIN : IDLE);
            IDLE:    w_state_nx = i_drain_req ? IDLE : RUN;
            default: w_state_nx = RUN;
        endcase
    end

`ifdef HRFP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_busy_cycles  <= '0;
            o_perf_stall_cycles <= '0;
        end else begin
            if (o_add_valid && !(&o_perf_busy_cycles))
                o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
            if ((|s_req.req_valid) && !w_xfer && !(&o_perf_stall_cycles))
                o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hrfp_add_sched.sv
// tb_hrfp_add_sched: randomized and directed scheduling checked against a queue-based model.
module tb_hrfp_add_sched;
    import hrfp_add_sched_pkg::*;
    localparam int NREQ = 4;
    localparam int PS = 5;
    localparam int MAXOUT = 3;

    typedef struct {
        int          due;
        int          rq;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hrfp_add_sched_if #(.NREQ(NREQ)) bus ();
    logic          add_valid;
    logic [DW-1:0] add_a, add_b, add_result;
    logic          drain_req = 1'b0;
    logic          drain_done, busy;
`ifdef HRFP_SCHED_PERF_EN
    logic [31:0]   perf_busy, perf_stall;
`endif

    hrfp_add_sched #(.NREQ(NREQ), .PIPELINESTAGES(PS), .MAXOUT(MAXOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_req       (bus),
        .o_add_valid (add_valid),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_result(add_result),
        .i_drain_req (drain_req),
        .o_drain_done(drain_done),
        .o_busy      (busy)
`ifdef HRFP_SCHED_PERF_EN
        ,
        .o_perf_busy_cycles (perf_busy),
        .o_perf_stall_cycles(perf_stall)
`endif
    );

    // Unresettable adder stand-in: sum appears PS cycles after the issue cycle.
    logic [DW-1:0] pipe [PS];
    always @(posedge clk) begin
        pipe[0] <= add_a + add_b;
        for (int k = 1; k < PS; k++) pipe[k] <= pipe[k-1];
    end
    assign add_result = pipe[PS-1];

    op_t           q[$];
    int            checks = 0, failures = 0;
    int            t = 0, last = NREQ - 1, mode = 0;
    logic          li_v = 1'b0;
    logic [DW-1:0] li_a, li_b;
    logic [DW-1:0] a_in [NREQ];
    logic [DW-1:0] b_in [NREQ];
    int            gcnt [NREQ];
    int            m_busy = 0, m_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = $urandom;
            b_in[i] = $urandom;
        end
    endtask

    task automatic clr_gcnt();
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        drain_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_add_valid", add_valid, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_drain_done", drain_done, 1'b0);
        rst = 1'b0;
        q.delete();
        last = NREQ - 1;
        mode = 0;
        li_v = 1'b0;
        m_busy = 0;
        m_stall = 0;
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic d);
        int g, di, n, j;
        logic [NREQ-1:0] er, eo;
        logic bz;
        @(negedge clk);
        bus.req_valid = v;
        drain_req = d;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*DW +: DW] = a_in[i];
            bus.req_b[i*DW +: DW] = b_in[i];
        end
        #1;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            n = 0;
            foreach (q[e]) if (q[e].rq == j) n++;
            if (g < 0 && v[j] && n < MAXOUT && mode == 0 && !d) g = j;
        end
        er = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("ready", bus.req_ready, er);
        for (int i = 0; i < NREQ; i++) gcnt[i] += int'(bus.req_ready[i]);
        check("add_valid", add_valid, li_v);
        if (li_v) begin
            check("add_a", add_a, li_a);
            check("add_b", add_b, li_b);
        end
        di = -1;
        foreach (q[e]) if (q[e].due == t) di = e;
        eo = (di >= 0) ? (NREQ'(1) << q[di].rq) : '0;
        check("rsp_valid", bus.rsp_valid, eo);
        if (di >= 0) check("rsp_data", bus.rsp_data, q[di].a + q[di].b);
        bz = (q.size() != 0);
        check("busy", busy, bz);
        check("drain_done", drain_done, mode == 2);
        m_busy += int'(li_v);
        m_stall += int'((|v) && g < 0);
        if (di >= 0) q.delete(di);
        mode = (mode == 0) ? (d ? 1 : 0) : (mode == 1) ? (!d ? 0 : (bz ? 1 : 2)) : (d ? 2 : 0);
        li_v = (g >= 0);
        if (g >= 0) begin
            li_a = a_in[g];
            li_b = b_in[g];
            q.push_back('{t + 1 + PS, g, a_in[g], b_in[g]});
            last = g;
        end
        t++;
    endtask

    initial begin
        logic d;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        rnd_ops();
        do_reset();

        a_in[2] = 32'h00A1B2C3;
        b_in[2] = 32'h00010203;
        step(4'b0100, 1'b0);
        repeat (8) step(4'b0000, 1'b0);

        clr_gcnt();
        for (int c = 0; c < 12; c++) begin
            rnd_ops();
            step(4'b1111, 1'b0);
        end
        for (int i = 0; i < NREQ; i++) check($sformatf("fair_grants%0d", i), gcnt[i], 3);
        repeat (10) step(4'b0000, 1'b0);

        clr_gcnt();
        for (int c = 0; c < 12; c++) begin
            rnd_ops();
            step(4'b0010, 1'b0);
        end
        check("credit_grants", gcnt[1], 6);
        repeat (10) step(4'b0000, 1'b0);

        repeat (4) begin
            rnd_ops();
            step(4'b1111, 1'b0);
        end
        for (int c = 0; c < 20 && !drain_done; c++) step(4'b1111, 1'b1);
        check("drain_reached", drain_done, 1'b1);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        repeat (10) step(4'b0000, 1'b0);

        repeat (3) begin
            rnd_ops();
            step(4'b1111, 1'b0);
        end
        do_reset();
        step(4'b1111, 1'b0);
        check("rst_first_grant", bus.req_ready, 4'b0001);

        d = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rnd_ops();
            if ($urandom_range(0, 19) == 0) d = ~d;
            step(NREQ'($urandom), d);
        end
        repeat (10) step(4'b0000, 1'b0);

`ifdef HRFP_SCHED_PERF_EN
        @(negedge clk);
        #1;
        check("perf_busy", perf_busy, m_busy);
        check("perf_stall", perf_stall, m_stall);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
